btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_pkg.sv | 24 ++
 rtl/btn_sync.sv | 26 ++
 rtl/btn_debounce.sv | 146 ++++++++++++++
 tb/tb_btn_debounce.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
// The state encoding is fixed at 2 bits so the FSM register is always two flops.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 20 ms debounce window and 3 s long-press threshold at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int unsigned LONG_CYCLES_DEF     = 150_000_000;

    localparam int unsigned DEBOUNCE_CYCLES_MAX = (1 << 20) - 1;
    localparam int unsigned LONG_CYCLES_MAX     = (1 << 28) - 1;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the asynchronous button pin.
// RST_VAL is the pin level when the button is released, so a reset
// never looks like a press to the downstream FSM.
module btn_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage resynchronisation into the clk domain
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Pushbutton debouncer with press/release/long-hold pulses.
// Optional long-press detection is built only when BTN_LONG_PRESS_EN is
// defined; otherwise the hold counter is absent and btn_long is tied low.
//
// state           | meaning
// ----------------+-----------------------------------------------------
// ST_IDLE         | button released, waiting for a pressed sample
// ST_PRESS_WAIT   | pressed samples being counted toward acceptance
// ST_PRESSED      | press accepted, btn_level high, hold time accumulating
// ST_RELEASE_WAIT | released samples being counted; btn_level still high
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > DEBOUNCE_CYCLES_MAX) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES out of range");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES || LONG_CYCLES > LONG_CYCLES_MAX) begin : g_bad_long
        $error("btn_debounce: LONG_CYCLES out of range");
    end

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYCLES - 1);

    btn_state_t      state;
    logic [DB_W-1:0] db_cnt;
    logic            raw_sync;
    logic            s;

    // Released pin level is the reset value so reset never fakes a press
    btn_sync #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (raw_sync)
    );

    assign s = ACTIVE_LOW ? ~raw_sync : raw_sync;

    // Debounce FSM: all outputs registered, pulses default low each cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            db_cnt      <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s) begin
                        state  <= ST_PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s) begin
                        state  <= ST_IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_TC) begin
                        state     <= ST_PRESSED;
                        db_cnt    <= '0;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!s) begin
                        state  <= ST_RELEASE_WAIT;
                        db_cnt <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (s) begin
                        state  <= ST_PRESSED;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_TC) begin
                        state       <= ST_IDLE;
                        db_cnt      <= '0;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    db_cnt    <= '0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned HOLD_W = cnt_width(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_TC  = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 2);

    logic [HOLD_W-1:0] hold_cnt;
    logic              release_done;

    // The cycle that takes the FSM back to IDLE also ends the hold
    assign release_done = (state == ST_RELEASE_WAIT) && !s && (db_cnt == DB_TC);

    // Hold timer: saturates at the threshold, so btn_long fires only on the
    // single step into saturation; survives release glitches via RELEASE_WAIT
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt <= '0;
            btn_long <= 1'b0;
        end else begin
            btn_long <= 1'b0;
            if (state == ST_PRESSED) begin
                if (hold_cnt != HOLD_TC) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    btn_long <= (hold_cnt == HOLD_PRE);
                end
            end else if (state == ST_IDLE || release_done) begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// ACTIVE_LOW=1. Long-press expectations follow BTN_LONG_PRESS_EN.
module tb_btn_debounce;

    localparam int DB = 4;
    localparam int LG = 20;
`ifdef BTN_LONG_PRESS_EN
    localparam int LONG_EXP = 1;
`else
    localparam int LONG_EXP = 0;
`endif

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic btn_raw = 1'b1;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_long;

    always #5 clk = ~clk;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LG),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int press_cnt, release_cnt, long_cnt, overlap_cnt, level_low_cnt;
    int press_at, release_at, long_at;
    int e, r, q;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        press_cnt     = 0;
        release_cnt   = 0;
        long_cnt      = 0;
        level_low_cnt = 0;
    endtask

    // Event recorder: cyc is the number of the posedge just taken
    always @(posedge clk) begin
        #1;
        cyc++;
        if (btn_press)   begin press_cnt++;   press_at   = cyc; end
        if (btn_release) begin release_cnt++; release_at = cyc; end
        if (btn_long)    begin long_cnt++;    long_at    = cyc; end
        if ((btn_press && btn_release) || (btn_press && btn_long) || (btn_release && btn_long))
            overlap_cnt++;
        if (!btn_level) level_low_cnt++;
    end

    initial begin
        overlap_cnt = 0;
        press_at = 0; release_at = 0; long_at = 0;
        clear_counts();

        // reset state
        wait_cyc(3);
        check_val("rst_level",   btn_level,   0);
        check_val("rst_press",   btn_press,   0);
        check_val("rst_release", btn_release, 0);
        check_val("rst_long",    btn_long,    0);
        rst = 1'b1;
        wait_cyc(3);

        // clean press, long hold, clean release
        clear_counts();
        btn_raw = 1'b0; e = cyc;
        wait_cyc(12);
        check_val("clean_press_cnt",   press_cnt, 1);
        check_val("clean_press_lat",   press_at - e, 7);
        check_val("clean_level_high",  btn_level, 1);
        wait_cyc(25);
        check_val("long_cnt",          long_cnt, LONG_EXP);
`ifdef BTN_LONG_PRESS_EN
        check_val("long_lat",          long_at - press_at, 19);
`endif
        btn_raw = 1'b1; r = cyc;
        wait_cyc(12);
        check_val("clean_release_cnt", release_cnt, 1);
        check_val("clean_release_lat", release_at - r, 7);
        check_val("clean_level_low",   btn_level, 0);
        check_val("long_no_second",    long_cnt, LONG_EXP);
        check_val("clean_press_once",  press_cnt, 1);

        // bounce: 2-cycle toggles for 12 cycles, then settle pressed
        clear_counts();
        for (int i = 0; i < 12; i++) begin
            btn_raw = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            wait_cyc(1);
        end
        btn_raw = 1'b0; e = cyc;
        check_val("bounce_no_press",   press_cnt, 0);
        wait_cyc(12);
        check_val("bounce_press_cnt",  press_cnt, 1);
        check_val("bounce_press_lat",  press_at - e, 7);
        btn_raw = 1'b1;
        wait_cyc(12);
        check_val("bounce_release",    release_cnt, 1);

        // release glitch while held
        clear_counts();
        btn_raw = 1'b0;
        wait_cyc(10);
        check_val("glitch_press",      press_cnt, 1);
        level_low_cnt = 0;
        btn_raw = 1'b1;
        wait_cyc(2);
        btn_raw = 1'b0;
        wait_cyc(10);
        check_val("glitch_level_held", level_low_cnt, 0);
        check_val("glitch_no_release", release_cnt, 0);
        check_val("glitch_no_press",   press_cnt, 1);
        btn_raw = 1'b1;
        wait_cyc(12);
        check_val("glitch_release",    release_cnt, 1);

        // reset while held
        clear_counts();
        btn_raw = 1'b0;
        wait_cyc(10);
        check_val("rmid_press",        press_cnt, 1);
        rst = 1'b0;
        wait_cyc(3);
        check_val("rmid_level",        btn_level, 0);
        check_val("rmid_press_out",    btn_press, 0);
        check_val("rmid_release_out",  btn_release, 0);
        check_val("rmid_long_out",     btn_long, 0);
        rst = 1'b1; q = cyc;
        wait_cyc(12);
        check_val("rmid_no_release",   release_cnt, 0);
        check_val("rmid_repress",      press_cnt, 2);
        check_val("rmid_repress_lat",  press_at - q, 7);
        check_val("rmid_level_high",   btn_level, 1);
        btn_raw = 1'b1;
        wait_cyc(12);
        check_val("rmid_release",      release_cnt, 1);

        check_val("pulse_overlap",     overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
